// File: rtl/serial_mult_pkg.sv
// serial_mult_pkg
// Shared types and helpers for the bit-serial x parallel multiplier.
//   state_t     : frame state (IDLE / RUN / FLUSH), exported for debug
//   cnt_width() : width of the per-frame bit counter for a given count range
//   prod_width(): number of product bits per frame (AW + BW)
// Configuration macro: SIGNED_MODE_EN (consumed by serial_mult_acc).
package serial_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int prod_width(input int aw, input int bw);
    return aw + bw;
  endfunction

  // Counter must index 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_mult_acc.sv
// serial_mult_acc
// Add/subtract-and-shift datapath of the serial multiplier.
//   clk, reset : clock, synchronous active-high reset
//   load_en    : load breg from b
//   b          : parallel operand B (BW bits)
//   step_en    : perform one step: sum = p + addend, p <= sum >> 1
//   a_term     : current A bit (already forced to 0 by the caller in FLUSH)
//   sub_en     : subtract breg instead of adding it (signed mode, last A bit)
//   clear      : clear the partial accumulator (abort / end of frame)
//   sum_lsb    : bit 0 of the current sum, i.e. the next product bit
// Configuration macro: SIGNED_MODE_EN selects two's-complement operation;
// when undefined the datapath is unsigned and sub_en has no effect.
module serial_mult_acc
  import serial_mult_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [BW-1:0] b,
  input  logic          step_en,
  input  logic          a_term,
  input  logic          sub_en,
  input  logic          clear,
  output logic          sum_lsb
);

  logic [BW-1:0] breg;
  logic [BW:0]   p;
  logic [BW+1:0] p_ext;
  logic [BW+1:0] b_ext;
  logic [BW+1:0] addend;
  logic [BW+1:0] sum;

`ifdef SIGNED_MODE_EN
  // Sign-extend both terms; taking sum[BW+1:1] is then an arithmetic shift,
  // and FLUSH steps (addend 0) replicate the sign of p.
  assign p_ext = {p[BW], p};
  assign b_ext = {{2{breg[BW-1]}}, breg};

  always_comb begin
    addend = '0;
    if (a_term) begin
      addend = sub_en ? -b_ext : b_ext;
    end
  end
`else
  assign p_ext  = {1'b0, p};
  assign b_ext  = {2'b00, breg};
  assign addend = a_term ? b_ext : '0;

  wire unused_sub_en = sub_en;
`endif

  assign sum     = p_ext + addend;
  assign sum_lsb = sum[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      breg <= '0;
      p    <= '0;
    end else begin
      if (load_en) begin
        breg <= b;
      end
      if (clear) begin
        p <= '0;
      end else if (step_en) begin
        p <= sum[BW+1:1];
      end
    end
  end

endmodule

// File: rtl/serial_mult_param.sv
// serial_mult_param
// Parametrised bit-serial (A) x parallel (B) multiplier, LSB-first product.
//   clk, reset : clock, synchronous active-high reset
//   start_a, A : serial A frame enable and A bit (LSB first, AW bits)
//   load_b, B  : parallel load strobe and operand B (BW bits), IDLE only
//   c, start_c : serial product bit and its qualifier (AW+BW bits per frame)
//   done       : one-cycle pulse with the last product bit
//   busy       : high from the first product bit through the done cycle
//   state_dbg  : current FSM state, for observation only
// Configuration macro: SIGNED_MODE_EN (two's-complement A and B).
//
// Stream semantics: there is no backpressure. An A bit is consumed on every
// rising edge where start_a is high (outside FLUSH); a product bit is valid
// on c in every cycle where start_c is high. Dropping start_a before the
// last A bit abandons the frame without emitting anything further.
module serial_mult_param
  import serial_mult_pkg::*;
#(
  parameter int AW = 4,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_a,
  input  logic          A,
  input  logic          load_b,
  input  logic [BW-1:0] B,
  output logic          c,
  output logic          start_c,
  output logic          done,
  output logic          busy,
  output state_t        state_dbg
);

  localparam int PW = prod_width(AW, BW);
  localparam int CW = cnt_width(PW);

  state_t        state;
  logic [CW-1:0] cnt;

  logic load_en;
  logic step_en;
  logic a_term;
  logic sub_en;
  logic clear;
  logic sum_lsb;

  logic frame_start;
  logic last_a;
  logic last_flush;

  assign frame_start = (state == IDLE) && !load_b && start_a;
  assign last_a      = (cnt == CW'(AW - 1));
  assign last_flush  = (cnt == CW'(PW - 1));

  assign load_en = (state == IDLE) && load_b;
  assign step_en = frame_start || ((state == RUN) && start_a) || (state == FLUSH);
  assign a_term  = (state != FLUSH) && A;
  assign sub_en  = (state == RUN) && last_a;
  assign clear   = ((state == RUN) && !start_a) || ((state == FLUSH) && last_flush);

  serial_mult_acc #(
    .BW (BW)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .b       (B),
    .step_en (step_en),
    .a_term  (a_term),
    .sub_en  (sub_en),
    .clear   (clear),
    .sum_lsb (sum_lsb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      c       <= 1'b0;
      start_c <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            // A bit 0 is consumed on the same edge that leaves IDLE.
            c       <= sum_lsb;
            start_c <= 1'b1;
            busy    <= 1'b1;
            cnt     <= CW'(1);
            state   <= RUN;
          end else begin
            c       <= 1'b0;
            start_c <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (start_a) begin
            c   <= sum_lsb;
            cnt <= cnt + CW'(1);
            if (last_a) begin
              state <= FLUSH;
            end
          end else begin
            c       <= 1'b0;
            start_c <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        FLUSH: begin
          c <= sum_lsb;
          if (last_flush) begin
            // start_c and busy stay high through the done cycle; IDLE drops
            // them on the next edge unless a new frame starts there.
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
